fetch_pc_reg: RTL
=================

Name: fetch_pc_reg

Overview:
- F-stage program counter plus F/D pipeline register for the 5-stage MIPS pipeline.
- Consumes the next-PC choice made by the D stage: redirect target `npc` and select `npc_sel` from the D-stage NPC unit.
- Holds `F_pc`, drives the instruction-memory word address, and latches fetched instruction and PC into D.
- Implements stall freeze and branch delay-slot semantics.

Parameters:
- PC_RESET, 32'h0000_3000, value loaded into `F_pc` on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction memory word 0.
- IM_WORDS, 4096, instruction memory depth in words; power of two.
- DELAY_SLOT, 1, 1 = instruction fetched in redirect cycle proceeds to D; 0 = it is squashed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  from hazard unit; freezes `F_pc` and F/D register
- npc_sel  input  1  from D-stage NPC unit; 1 = take `npc`
- npc  input  32  D-stage redirect target (branch/jal/jr)
- im_rdata  input  32  instruction word read combinationally at `im_addr`
- im_addr  output  log2(IM_WORDS)  word index = (F_pc - IM_BASE) >> 2, low bits
- F_pc  output  32  current fetch PC
- F_pc_add_4  output  32  F_pc + 4, mod 2^32
- D_pc  output  32  PC of instruction in D
- D_instr  output  32  instruction in D (0 = nop)
- D_valid  output  1  D holds a real fetched instruction
- D_fault  output  1  D instruction came from a misaligned or out-of-range fetch

Behaviour:
- All state updates on rising `clk`. Reset is synchronous and active-high, and has priority over `stall`.
- Reset values:
  - F_pc = PC_RESET
  - D_pc = 0, D_instr = 0, D_valid = 0, D_fault = 0
  - im_addr and F_pc_add_4 follow F_pc combinationally.
- Fetch fault (combinational):
  - F_fault = (F_pc[1:0] != 0) or (F_pc < IM_BASE) or (F_pc >= IM_BASE + 4*IM_WORDS).
  - Unsigned 32-bit compare; the upper bound is computed in 33 bits so a range ending at 2^32 does not overflow.
- PC update, when !reset && !stall:
  - F_pc <= npc_sel ? npc : F_pc_add_4.
  - F_pc_add_4 wraps 32'hFFFF_FFFC -> 0.
- F/D update, when !reset && !stall:
  - D_pc <= F_pc
  - D_instr <= F_fault ? 0 : im_rdata
  - D_fault <= F_fault
  - D_valid <= 1
- Squash when DELAY_SLOT = 0 and npc_sel = 1: D_instr <= 0, D_valid <= 0, D_fault <= 0; D_pc still <= F_pc.
- Delay slot when DELAY_SLOT = 1: the instruction fetched in the redirect cycle (PC of branch + 4) enters D normally. No flush exists in this block.
- Stall:
  - F_pc and all D_* hold their values.
  - npc_sel and npc are ignored during stall. The stalled D-stage branch re-asserts them in the cycle stall drops. This block keeps no pending-redirect state.
- Fault is reported, not trapped:
  - The faulting PC still advances by the normal rules.
  - `im_rdata` is not used when F_fault = 1.
- Latency:
  - Redirect is visible on F_pc one cycle after npc_sel is sampled.
  - Fetched word is visible on D_instr one cycle after F_pc.
- Reset mid-stall or mid-redirect: reset wins; the next cycle fetches PC_RESET.

Test Plan:
- Reset then 3 cycles, stall = 0, npc_sel = 0 → F_pc = 3000, 3004, 3008, 300C. D_pc trails by one cycle. D_valid rises the cycle after reset drops. im_addr = 0, 1, 2, 3.
- Branch at 3008 in D with npc_sel = 1, npc = 3040, DELAY_SLOT = 1 → next F_pc = 3040. D receives 300C (delay slot) with D_valid = 1, then 3040.
- Same redirect with DELAY_SLOT = 0 → D_instr = 0, D_valid = 0, D_pc = 300C. The following cycle D_pc = 3040.
- Stall held 2 cycles with npc_sel = 1, npc = 3100 during stall → F_pc and D_* frozen and redirect ignored. After stall drops, npc_sel = 1 is applied: F_pc = 3100 one cycle later.
- Faults:
  - npc = 3002 → D_fault = 1, D_instr = 0.
  - npc = 3000 + 4*IM_WORDS → D_fault = 1.
  - npc = 2FFC → D_fault = 1.
  - Sequential fetch continues: 3006 after 3002.
- Wrap and reset:
  - F_pc forced to FFFF_FFFC via npc → next F_pc = 0, with fault flagged.
  - Reset asserted together with stall = 1 and npc_sel = 1 → F_pc = 3000, D cleared.

Source files
------------

// File: rtl/fetch_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
//   F-stage program counter and F/D pipeline register for the 5-stage MIPS
//   pipeline. The D-stage NPC unit chooses the next PC (npc_sel/npc); this
//   block holds F_pc, drives the instruction-memory word index and latches
//   the fetched word plus its PC into D.
//
//   Flow control: `stall` is a hold request from the hazard unit. While it is
//   high, F_pc and every D_* register keep their value and npc_sel/npc are
//   ignored. There is no handshake beyond that and no pending-redirect state:
//   a stalled D-stage branch re-asserts npc_sel in the cycle stall drops.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (wins over stall)
//   stall       freeze F_pc and the F/D register
//   npc_sel     1 = next PC is npc, 0 = F_pc + 4
//   npc         redirect target from the D stage
//   im_rdata    instruction word read combinationally at im_addr
//   im_addr     word index (F_pc - IM_BASE) >> 2, low log2(IM_WORDS) bits
//   F_pc        current fetch PC
//   F_pc_add_4  F_pc + 4 (wraps mod 2^32)
//   D_pc        PC of the instruction in D
//   D_instr     instruction in D (0 = nop)
//   D_valid     D holds a real fetched instruction
//   D_fault     D instruction came from a misaligned/out-of-range fetch
// -----------------------------------------------------------------------------
module fetch_pc_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096,
  parameter bit          DELAY_SLOT = 1'b1,
  localparam int         AW         = $clog2(IM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          npc_sel,
  input  logic [31:0]   npc,
  input  logic [31:0]   im_rdata,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   F_pc,
  output logic [31:0]   F_pc_add_4,
  output logic [31:0]   D_pc,
  output logic [31:0]   D_instr,
  output logic          D_valid,
  output logic          D_fault
);

  // One past the last instruction byte. Kept in 33 bits so a memory that ends
  // exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        d_valid_q, d_valid_d;
  logic        d_fault_q, d_fault_d;

  logic [31:0] pc_add_4;
  logic [31:0] pc_off;
  logic        f_fault;

  assign pc_add_4 = f_pc_q + 32'd4;
  assign pc_off   = f_pc_q - IM_BASE;
  assign im_addr  = AW'(pc_off >> 2);

  assign f_fault = (f_pc_q[1:0] != 2'b00)
                 | (f_pc_q < IM_BASE)
                 | ({1'b0, f_pc_q} >= IM_END);

  always_comb begin
    f_pc_d    = f_pc_q;
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
    d_valid_d = d_valid_q;
    d_fault_d = d_fault_q;
    if (!stall) begin
      // A faulting PC still advances normally; the fault is only reported.
      f_pc_d = npc_sel ? npc : pc_add_4;
      d_pc_d = f_pc_q;
      if (!DELAY_SLOT && npc_sel) begin
        // No delay slot: the word fetched alongside the redirect is dropped.
        d_instr_d = 32'd0;
        d_valid_d = 1'b0;
        d_fault_d = 1'b0;
      end else begin
        // im_rdata is meaningless for a faulting fetch, so a nop goes down.
        d_instr_d = f_fault ? 32'd0 : im_rdata;
        d_valid_d = 1'b1;
        d_fault_d = f_fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= PC_RESET;
      d_pc_q    <= 32'd0;
      d_instr_q <= 32'd0;
      d_valid_q <= 1'b0;
      d_fault_q <= 1'b0;
    end else begin
      f_pc_q    <= f_pc_d;
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
      d_valid_q <= d_valid_d;
      d_fault_q <= d_fault_d;
    end
  end

  assign F_pc       = f_pc_q;
  assign F_pc_add_4 = pc_add_4;
  assign D_pc       = d_pc_q;
  assign D_instr    = d_instr_q;
  assign D_valid    = d_valid_q;
  assign D_fault    = d_fault_q;

endmodule
